// File: rtl/rv32v_vmem_sequencer_pkg.sv
// Shared types for the vector memory sequencer: FSM states, element widths,
// the scalar load_type encoding driven to the load-store controller, and the
// eew -> load_type mapping.
package rv32v_vmem_sequencer_pkg;

  // Default maximum element count per instruction (power of two).
  localparam int unsigned VSEQ_VLMAX = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StFin
  } vseq_state_t;

  // 2'b11 is an illegal element width and has no enumerator.
  typedef enum logic [1:0] {
    Eew8  = 2'b00,
    Eew16 = 2'b01,
    Eew32 = 2'b10
  } eew_t;

  // Scalar load/store size encoding as understood by the LSC.
  typedef enum logic [2:0] {
    LoadLb  = 3'b000,
    LoadLh  = 3'b001,
    LoadLw  = 3'b010,
    LoadLbu = 3'b100,
    LoadLhu = 3'b101
  } load_type_t;

  // Vector loads are never sign-extended; stores only need the size.
  function automatic load_type_t eew_to_load_type(input logic [1:0] eew,
                                                  input logic       is_store);
    load_type_t lt;
    lt = LoadLw;
    case (eew)
      Eew8:    lt = is_store ? LoadLb : LoadLbu;
      Eew16:   lt = is_store ? LoadLh : LoadLhu;
      default: lt = LoadLw;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/rv32v_vmem_sequencer_addr_gen.sv
// Element address generator: holds the running element address and the
// latched stride, flags misaligned half/word elements and maps eew to the
// scalar load type.
module rv32v_vseq_addr_gen
  import rv32v_vmem_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [31:0] base_i,
  input  logic [31:0] stride_i,
  input  logic [1:0]  eew_i,
  input  logic        is_store_i,
  output logic [31:0] addr_o,
  output logic        misaligned_o,
  output load_type_t  load_type_o
);

  logic [31:0] addr_d, addr_q;
  logic [31:0] stride_d, stride_q;

  // Next address: reload on launch, otherwise step by the (signed) stride.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    if (load_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
    end else if (adv_i) begin
      addr_d = addr_q + stride_q;  // wraps mod 2^32 by design
    end
  end

  // Address and stride registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  // Natural alignment check for the current element.
  always_comb begin
    misaligned_o = 1'b0;
    case (eew_i)
      Eew16:   misaligned_o = addr_q[0];
      Eew32:   misaligned_o = |addr_q[1:0];
      default: misaligned_o = 1'b0;
    endcase
  end

  assign addr_o      = addr_q;
  assign load_type_o = eew_to_load_type(eew_i, is_store_i);

endmodule

// File: rtl/rv32v_vmem_sequencer.sv
// Vector load/store sequencer: splits one vector memory instruction into
// scalar element accesses on the LSC, skipping masked-off elements and
// stopping at the first misaligned active element.
// Optional build macro: RV32V_VSEQ_PERF_EN adds stall/element perf counters.
module rv32v_vmem_sequencer
  import rv32v_vmem_sequencer_pkg::*;
#(
  parameter int unsigned VLMAX = VSEQ_VLMAX,
  parameter int unsigned IDX_W = $clog2(VLMAX)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             is_store,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      stride,
  input  logic [1:0]       eew,
  input  logic [IDX_W:0]   vl,
  input  logic             vm,
  input  logic [VLMAX-1:0] vmask,
  input  logic             kill,
  input  logic [31:0]      store_data,
  input  logic             lsc_ready,
  input  logic [31:0]      lsc_dload,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [IDX_W-1:0] fault_idx,
  output logic [IDX_W-1:0] elem_idx,
  output logic             lsc_ren,
  output logic             lsc_wen,
  output logic [31:0]      lsc_addr,
  output logic [2:0]       lsc_load_type,
  output logic [31:0]      lsc_store_data,
  output logic             wb_en,
  output logic [IDX_W-1:0] wb_idx,
  output logic [31:0]      wb_data,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_elem_cnt
);

  vseq_state_t state_d, state_q;

  logic [IDX_W-1:0] idx_d, idx_q;
  logic [IDX_W-1:0] fault_idx_d, fault_idx_q;
  logic [IDX_W:0]   vl_d, vl_q;
  logic [VLMAX-1:0] vmask_d, vmask_q;
  logic [1:0]       eew_d, eew_q;
  logic             vm_d, vm_q;
  logic             is_store_d, is_store_q;
  logic             fault_r_d, fault_r_q;
  logic             kill_d, kill_q;

  logic             active, req, req_out, last, kill_eff;
  logic             ag_load, ag_adv, ag_misaligned;
  logic [31:0]      ag_addr;
  load_type_t       ag_load_type;

  rv32v_vseq_addr_gen u_addr_gen (
    .clk_i        (CLK),
    .rst_i        (RST),
    .load_i       (ag_load),
    .adv_i        (ag_adv),
    .base_i       (base_addr),
    .stride_i     (stride),
    .eew_i        (eew_q),
    .is_store_i   (is_store_q),
    .addr_o       (ag_addr),
    .misaligned_o (ag_misaligned),
    .load_type_o  (ag_load_type)
  );

  // Per-element decode of the current ACCESS cycle.
  always_comb begin
    active   = vm_q | vmask_q[idx_q];
    req      = (state_q == StAccess) & active & ~ag_misaligned;
    req_out  = req & ~RST;
    last     = (({1'b0, idx_q} + 1'b1) == vl_q);
    // A kill seen while a request stalls is remembered until it completes.
    kill_eff = kill | kill_q;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = ((vl == '0) || (eew == 2'b11)) ? StFin : StAccess;
        end
      end
      StAccess: begin
        if (kill_eff && (!req || lsc_ready)) begin
          state_d = StIdle;
        end else if (active && ag_misaligned) begin
          state_d = StFin;
        end else if ((!active || lsc_ready) && last) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Instruction context: latched on launch, stepped per completed element.
  always_comb begin
    idx_d       = idx_q;
    fault_idx_d = fault_idx_q;
    vl_d        = vl_q;
    vmask_d     = vmask_q;
    eew_d       = eew_q;
    vm_d        = vm_q;
    is_store_d  = is_store_q;
    fault_r_d   = fault_r_q;
    kill_d      = kill_q;
    ag_load     = 1'b0;
    ag_adv      = 1'b0;
    if ((state_q == StIdle) && start) begin
      idx_d       = '0;
      fault_idx_d = '0;
      vl_d        = vl;
      vmask_d     = vmask;
      eew_d       = eew;
      vm_d        = vm;
      is_store_d  = is_store;
      fault_r_d   = (eew == 2'b11);
      kill_d      = 1'b0;
      ag_load     = 1'b1;
    end else if (state_q == StAccess) begin
      if (kill && req && !lsc_ready) begin
        kill_d = 1'b1;
      end
      if (active && ag_misaligned) begin
        if (!kill_eff) begin
          fault_r_d   = 1'b1;
          fault_idx_d = idx_q;
        end
      end else if (!active || lsc_ready) begin
        idx_d  = idx_q + 1'b1;
        ag_adv = 1'b1;
      end
    end
  end

  // Context registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q       <= '0;
      fault_idx_q <= '0;
      vl_q        <= '0;
      vmask_q     <= '0;
      eew_q       <= '0;
      vm_q        <= 1'b0;
      is_store_q  <= 1'b0;
      fault_r_q   <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      fault_idx_q <= fault_idx_d;
      vl_q        <= vl_d;
      vmask_q     <= vmask_d;
      eew_q       <= eew_d;
      vm_q        <= vm_d;
      is_store_q  <= is_store_d;
      fault_r_q   <= fault_r_d;
      kill_q      <= kill_d;
    end
  end

  // FSM outputs; requests drop in the same cycle RST is raised.
  always_comb begin
    busy           = (state_q == StAccess);
    done           = (state_q == StFin) & ~RST;
    fault          = (state_q == StFin) & ~RST & fault_r_q;
    fault_idx      = fault_idx_q;
    elem_idx       = idx_q;
    lsc_ren        = req_out & ~is_store_q;
    lsc_wen        = req_out & is_store_q;
    lsc_addr       = req_out ? ag_addr : '0;
    lsc_load_type  = ag_load_type;
    lsc_store_data = store_data;
    wb_en          = req_out & ~is_store_q & lsc_ready;
    wb_idx         = idx_q;
    wb_data        = lsc_dload;
  end

`ifdef RV32V_VSEQ_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] elem_cnt_d, elem_cnt_q;

  // Free-running perf counters, cleared only by RST.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, req & ~lsc_ready};
    elem_cnt_d  = elem_cnt_q + {31'b0, req & lsc_ready};
  end

  // Perf counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      elem_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_elem_cnt  = elem_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_elem_cnt  = '0;
`endif

endmodule
